// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit LFSR stage: checker states, seed and the
// single home of the tap equations used by generator and checker alike.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } chk_state_t;

  localparam logic [5:0] LFSR_SEED = 6'h3F;

  function automatic logic [5:0] lfsr_nxt(input logic [5:0] s);
    logic [5:0] n;
    n[0] = s[5];
    n[1] = s[0];
    n[2] = s[1] ^ s[5];
    n[3] = s[2];
    n[4] = s[3];
    n[5] = s[4];
    return n;
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Sample stream into the checker and its status/error outputs.
interface lfsr_checker_if #(
  parameter int ERR_W = 16
);
  logic             vld_in;
  logic [5:0]       q_in;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output vld_in, q_in, clr_cnt,
    input  locked, err, err_cnt
  );

  modport slave (
    input  vld_in, q_in, clr_cnt,
    output locked, err, err_cnt
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 6-bit LFSR: searches, verifies, then
// flywheels its prediction and counts mismatches while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

  chk_state_t       state_reg, state_next;
  logic [5:0]       pred_reg, pred_next;
  logic [3:0]       mcnt_reg, mcnt_next;
  logic [3:0]       xcnt_reg, xcnt_next;
  logic             err_reg, err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic [5:0]       q_nxt;
  logic             miss;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= SEARCH;
      pred_reg    <= LFSR_SEED;
      mcnt_reg    <= '0;
      xcnt_reg    <= '0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pred_reg    <= pred_next;
      mcnt_reg    <= mcnt_next;
      xcnt_reg    <= xcnt_next;
      err_reg     <= err_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pred_next    = pred_reg;
    mcnt_next    = mcnt_reg;
    xcnt_next    = xcnt_reg;
    err_next     = 1'b0;
    err_cnt_next = err_cnt_reg;
    q_nxt        = lfsr_nxt(bus.q_in);
    miss         = (bus.q_in != pred_reg);

    if (bus.vld_in) begin
      unique case (state_reg)
        SEARCH: begin
          if (bus.q_in != 6'h00) begin
            pred_next  = q_nxt;
            mcnt_next  = '0;
            state_next = VERIFY;
          end
        end
        VERIFY: begin
          if (!miss) begin
            mcnt_next = mcnt_reg + 4'd1;
            pred_next = q_nxt;
            if (mcnt_reg + 4'd1 == LOCK_C) begin
              state_next = LOCKED;
              xcnt_next  = '0;
            end
          end else if (bus.q_in == 6'h00) begin
            mcnt_next  = '0;
            state_next = SEARCH;
          end else begin
            pred_next = q_nxt;
            mcnt_next = '0;
          end
        end
        LOCKED: begin
          // Flywheel: never re-seed from the input once locked.
          pred_next = lfsr_nxt(pred_reg);
          if (miss) begin
            err_next  = 1'b1;
            xcnt_next = xcnt_reg + 4'd1;
            if (err_cnt_reg != '1)
              err_cnt_next = err_cnt_reg + ERR_W'(1);
            if (xcnt_reg + 4'd1 == LOSS_C)
              state_next = SEARCH;
          end else begin
            xcnt_next = '0;
          end
        end
        default: state_next = SEARCH;
      endcase
    end

    if (bus.clr_cnt)
      err_cnt_next = '0;
  end

  assign bus.locked  = (state_reg == LOCKED);
  assign bus.err     = err_reg;
  assign bus.err_cnt = err_cnt_reg;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Pseudo-random sequence checker placed directly downstream of the 6-bit LFSR generator. It samples the generator's parallel state word and self-synchronises to the sequence. Once locked, it predicts every following word, flags mismatches and keeps a saturating error count. It serves as the built-in self-check for the LFSR stage and for any link that carries its output.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive correct predictions required to declare lock (1..15)
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock (1..15)
- ERR_W, 16: width of the error counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; clock clk
- vld_in  in  1  q_in carries a valid sample this cycle
- q_in  in  6  LFSR state word under check
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  checker is in LOCKED state
- err  out  1  one-cycle pulse for each mismatching sample while locked
- err_cnt  out  ERR_W  saturating count of mismatches seen while locked

## Operation
- Next-state function nxt(s), applied to the LFSR word: nxt[0]=s[5], nxt[1]=s[0], nxt[2]=s[1]^s[5], nxt[3]=s[2], nxt[4]=s[3], nxt[5]=s[4].
- Reference sequence from the 6'h3F seed: 3F, 3B, 33, 23, 03, 06, 0C.
- Internal registers:
  - pred: the predicted word (6 bits)
  - mcnt: match counter (4 bits)
  - xcnt: consecutive-miss counter (4 bits)
  - state
- Cycles with vld_in=0 are ignored entirely. No state, counter or output changes, except that err returns to 0 and clr_cnt still acts.
- State machine:
  - SEARCH, on a valid sample:
    - q_in==0 (the lock-up word): stay in SEARCH.
    - Otherwise: pred<=nxt(q_in), mcnt<=0, go to VERIFY.
  - VERIFY, on a valid sample:
    - q_in==pred: mcnt<=mcnt+1, pred<=nxt(q_in). If mcnt+1==LOCK_CNT, go to LOCKED with xcnt<=0.
    - Mismatch: re-seed with pred<=nxt(q_in) and mcnt<=0, stay in VERIFY. A q_in of 0 returns the checker to SEARCH instead.
  - LOCKED, on a valid sample:
    - Every valid sample sets pred<=nxt(pred), i.e. the checker flywheels and never re-seeds from a bad input.
    - Match: xcnt<=0.
    - Mismatch: err<=1, err_cnt<=err_cnt+1 (saturating at all-ones), xcnt<=xcnt+1. If xcnt+1==LOSS_CNT, go to SEARCH.
- Mismatches in SEARCH or VERIFY never assert err and never count.
- clr_cnt=1 sets err_cnt<=0 and takes precedence over a same-cycle increment. It does not affect state, pred or locked.
- Reset values: state=SEARCH, pred=6'h3F, mcnt=0, xcnt=0, locked=0, err=0, err_cnt=0.
- Reset asserted mid-operation drops lock immediately, asynchronously.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- locked rises in the cycle after the edge that samples the LOCK_CNT-th match.
- locked falls in the cycle after the edge that samples the LOSS_CNT-th consecutive miss.
- err is high for exactly the one cycle following the edge that samples the mismatching word. err_cnt updates on that same edge.
- Back-to-back mismatches give back-to-back err pulses.
- Throughput is one sample per clock. There is no backpressure and no stall.
- Minimum lock latency is LOCK_CNT+1 valid samples after the first non-zero sample.

## Structure
- Package lfsr_pkg holds:
  - the state enum {SEARCH, VERIFY, LOCKED}
  - the constant LFSR_SEED=6'h3F
  - the function lfsr_nxt(s) implementing the tap equations above
- The generator side and any future generator use the same function, so the tap set is defined in one place.
- The checker is a single module; a separate sub-module is unnecessary.
- The bench instantiates the existing LFSR generator feeding lfsr_checker, plus a direct-drive mode that forces q_in.

## Test plan
- **Lock from seed.** Apply reset low for 25 ns, then feed the generator output with vld_in=1 and LOCK_CNT=4. Samples 3F, 3B, 33, 23, 03 must raise locked in the cycle after the 03 sample, with err=0 and err_cnt=0.
- **Single error.** Once locked, force one sample to 06→07. Expect exactly one err pulse, err_cnt=1 and locked held. The next correct sample 0C is still a match, confirming the flywheel behaviour.
- **Loss of lock.** Once locked, inject 3 consecutive wrong words with LOSS_CNT=3. Expect three err pulses, err_cnt=3, and locked low after the third miss. The checker then relocks after 5 valid correct samples.
- **Valid gaps and lock-up word.** Insert vld_in=0 cycles between samples, carrying garbage q_in; lock timing must be unchanged. Feeding q_in=0 in SEARCH must keep locked=0 indefinitely.
- **Counter edge cases.** With ERR_W=2, produce 5 errors: err_cnt must saturate at 3. Assert clr_cnt together with an error: err_cnt must read 0 next cycle.
- **Reset mid-operation.** Assert rst low while locked, asynchronously between edges. locked, err and err_cnt must go to 0 immediately, and the checker must relock normally after release.
